mdio_slave: RTL and testbench

PHY-side MDIO management responder: decodes IEEE 802.3 Clause 22 frames issued by an MDIO master, such as the UART-driven management path. It holds a 32 x 16-bit register file and answers reads by driving MDIO. It reports accepted writes to local logic. It is used in loopback benches and as a stand-in PHY management interface on boards without a real PHY.

---
 rtl/mdio_pkg.sv | 27 ++
 rtl/mdio_sync_edge.sv | 43 ++++
 rtl/mdio_slave.sv | 180 ++++++++++++++++++
 tb/tb_mdio_slave.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mdio_pkg.sv
// mdio_pkg: shared Clause 22 constants and FSM state encoding for mdio_slave.
package mdio_pkg;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] ST_PATTERN = 2'b01;

  localparam int DATA_W   = 16;
  localparam int REG_NUM  = 32;

  // Last bit index of each counted field (bit counter starts at 0).
  localparam logic [4:0] ADDR_LAST = 5'd4;   // PHYAD / REGAD are 5 bits
  localparam logic [4:0] WD_LAST   = 5'd15;  // 16 write data bits
  localparam logic [4:0] RD_LAST   = 5'd17;  // TA bit 2 + 16 data rises
  localparam logic [4:0] SKIP_LAST = 5'd22;  // REGAD + TA + DATA = 23 bits

  localparam logic [5:0] PRE_SAT   = 6'd32;

  localparam logic [3:0] S_PRE    = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_OPCODE = 4'd2;
  localparam logic [3:0] S_PHYAD  = 4'd3;
  localparam logic [3:0] S_REGAD  = 4'd4;
  localparam logic [3:0] S_TA     = 4'd5;
  localparam logic [3:0] S_WDATA  = 4'd6;
  localparam logic [3:0] S_RDATA  = 4'd7;
  localparam logic [3:0] S_SKIP   = 4'd8;
endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: synchronizes mdc_i/mdio_i into clk125 and emits one-cycle
// mdc rise/fall pulses, with mdio delayed to line up with the pulses.
module mdio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk125,
  input  logic reset,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdcRise,
  output logic mdcFall,
  output logic mdioSync
);
  logic [SYNC_STAGES-1:0] mdcSh;
  logic [SYNC_STAGES-1:0] mdioSh;
  logic                   mdcPrev;

  // Synchronizer chains; an idle MDIO bus sits high, so reset to 1 to avoid a fake edge.
  always_ff @(posedge clk125) begin
    if (reset) begin
      mdcSh  <= '1;
      mdioSh <= '1;
    end else begin
      mdcSh  <= {mdcSh[SYNC_STAGES-2:0], mdc_i};
      mdioSh <= {mdioSh[SYNC_STAGES-2:0], mdio_i};
    end
  end

  // Registered edge pulses; mdio gets the same extra flop so it aligns with the pulse.
  always_ff @(posedge clk125) begin
    if (reset) begin
      mdcPrev  <= 1'b1;
      mdcRise  <= 1'b0;
      mdcFall  <= 1'b0;
      mdioSync <= 1'b1;
    end else begin
      mdcPrev  <= mdcSh[SYNC_STAGES-1];
      mdcRise  <= mdcSh[SYNC_STAGES-1] & ~mdcPrev;
      mdcFall  <= ~mdcSh[SYNC_STAGES-1] & mdcPrev;
      mdioSync <= mdioSh[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/mdio_slave.sv
// mdio_slave: Clause 22 MDIO responder with a 32 x 16 register file.
// Build option: define MDIO_SLAVE_PREAMBLE_EN to require a full 32-bit
// preamble before ST; otherwise one sampled 1 is enough (preamble suppression).
module mdio_slave
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [15:0] PHY_ID1     = 16'h0022,
  parameter logic [15:0] PHY_ID2     = 16'h1620,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk125,
  input  logic        reset,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  output logic        wr_valid,
  output logic [4:0]  wr_reg_addr,
  output logic [15:0] wr_data,
  output logic        busy
);
  logic              mdcRise, mdcFall, mdioSync;
  logic [3:0]        state;
  logic [4:0]        bitCnt;
  logic [5:0]        preCnt;
  logic              preOk, opRead, opFirst, wrHit;
  logic [3:0]        phySh, regSh;
  logic [4:0]        regAd;
  logic [DATA_W-1:0] shiftReg;
  logic [14:0]       wdSh;
  logic [DATA_W-1:0] regFile [REG_NUM];

  mdio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSync (
    .clk125   (clk125),
    .reset    (reset),
    .mdc_i    (mdc_i),
    .mdio_i   (mdio_i),
    .mdcRise  (mdcRise),
    .mdcFall  (mdcFall),
    .mdioSync (mdioSync)
  );

`ifdef MDIO_SLAVE_PREAMBLE_EN
  assign preOk = (preCnt == PRE_SAT);
`else
  assign preOk = (preCnt != 6'd0);
`endif

  assign busy  = (state != S_PRE);
  // Last write data bit of a frame aimed at a writable register.
  assign wrHit = mdcRise && (state == S_WDATA) && (bitCnt == WD_LAST) &&
                 (regAd != 5'd2) && (regAd != 5'd3);

  // Register file: IDs reload on reset and are never written.
  always_ff @(posedge clk125) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) regFile[i] <= '0;
      regFile[2] <= PHY_ID1;
      regFile[3] <= PHY_ID2;
    end else if (wrHit) begin
      regFile[regAd] <= {wdSh, mdioSync};
    end
  end

  // Frame FSM: fields sampled on mdc rise, pad outputs updated on mdc fall.
  always_ff @(posedge clk125) begin
    if (reset) begin
      state       <= S_PRE;
      bitCnt      <= '0;
      preCnt      <= '0;
      opRead      <= 1'b0;
      opFirst     <= 1'b0;
      phySh       <= '0;
      regSh       <= '0;
      regAd       <= '0;
      shiftReg    <= '0;
      wdSh        <= '0;
      mdio_o      <= 1'b1;
      mdio_t      <= 1'b1;
      wr_valid    <= 1'b0;
      wr_reg_addr <= '0;
      wr_data     <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (wrHit) begin
        wr_valid    <= 1'b1;
        wr_reg_addr <= regAd;
        wr_data     <= {wdSh, mdioSync};
      end
      if (mdcRise) begin
        case (state)
          S_PRE: begin
            if (mdioSync) begin
              if (preCnt != PRE_SAT) preCnt <= preCnt + 6'd1;
            end else begin
              preCnt <= '0;
              if (preOk) state <= S_START;
            end
          end
          S_START: begin
            bitCnt <= '0;
            state  <= (mdioSync == ST_PATTERN[0]) ? S_OPCODE : S_PRE;
          end
          S_OPCODE: begin
            if (bitCnt == 5'd0) begin
              opFirst <= mdioSync;
              bitCnt  <= 5'd1;
            end else begin
              bitCnt <= '0;
              opRead <= ({opFirst, mdioSync} == OP_READ);
              if ({opFirst, mdioSync} == OP_READ || {opFirst, mdioSync} == OP_WRITE)
                state <= S_PHYAD;
              else
                state <= S_PRE;
            end
          end
          S_PHYAD: begin
            phySh <= {phySh[2:0], mdioSync};
            if (bitCnt == ADDR_LAST) begin
              bitCnt <= '0;
              state  <= ({phySh, mdioSync} == PHY_ADDR) ? S_REGAD : S_SKIP;
            end else bitCnt <= bitCnt + 5'd1;
          end
          S_REGAD: begin
            regSh <= {regSh[2:0], mdioSync};
            if (bitCnt == ADDR_LAST) begin
              bitCnt <= '0;
              regAd  <= {regSh, mdioSync};
              if (opRead) shiftReg <= regFile[{regSh, mdioSync}];
              state  <= S_TA;
            end else bitCnt <= bitCnt + 5'd1;
          end
          S_TA: begin
            if (opRead) bitCnt <= bitCnt + 5'd1;
            else if (bitCnt == 5'd0) begin
              if (mdioSync) bitCnt <= 5'd1;
              else state <= S_PRE;
            end else begin
              bitCnt <= '0;
              state  <= mdioSync ? S_PRE : S_WDATA;
            end
          end
          S_WDATA: begin
            wdSh <= {wdSh[13:0], mdioSync};
            if (bitCnt == WD_LAST) begin
              bitCnt <= '0;
              state  <= S_PRE;
            end else bitCnt <= bitCnt + 5'd1;
          end
          S_RDATA: bitCnt <= bitCnt + 5'd1;
          S_SKIP: begin
            if (bitCnt == SKIP_LAST) begin
              bitCnt <= '0;
              state  <= S_PRE;
            end else bitCnt <= bitCnt + 5'd1;
          end
          default: state <= S_PRE;
        endcase
      end else if (mdcFall) begin
        if (state == S_TA && opRead && bitCnt == 5'd1) begin
          mdio_o <= 1'b0;
          mdio_t <= 1'b0;
          bitCnt <= '0;
          state  <= S_RDATA;
        end else if (state == S_RDATA) begin
          if (bitCnt == RD_LAST) begin
            mdio_o <= 1'b1;
            mdio_t <= 1'b1;
            bitCnt <= '0;
            state  <= S_PRE;
          end else begin
            mdio_o   <= shiftReg[15];
            shiftReg <= {shiftReg[14:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_slave.sv
// tb_mdio_slave: MDIO master driver plus frame-level model of the responder.
module tb_mdio_slave;
  logic        clk125 = 1'b0;
  logic        reset  = 1'b1;
  logic        mdc_i  = 1'b1;
  logic        mdio_i = 1'b1;
  logic        mdio_o, mdio_t, wr_valid, busy;
  logic [4:0]  wr_reg_addr;
  logic [15:0] wr_data;

  int nChk = 0, nBad = 0;
  int onesRun = 0, trail = 0, wrCnt = 0;
  logic expT = 1'b1, expO = 1'b1, chkEn = 1'b0, wrPrev = 1'b0;
  logic [15:0] mdl [32];
  logic [4:0]  qA [$];
  logic [15:0] qD [$];

  always #4 clk125 = ~clk125;

  mdio_slave dut (
    .clk125      (clk125),
    .reset       (reset),
    .mdc_i       (mdc_i),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_t      (mdio_t),
    .wr_valid    (wr_valid),
    .wr_reg_addr (wr_reg_addr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mdlReset();
    for (int i = 0; i < 32; i++) mdl[i] = 16'h0000;
    mdl[2] = 16'h0022;
    mdl[3] = 16'h1620;
    qA.delete();
    qD.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk125);
    #1;
  endtask

  // Per-cycle compare against the expectation of the current bit, plus write events.
  always @(negedge clk125) begin
    if (reset) wrPrev = 1'b0;
    else begin
      if (chkEn) begin
        check("mdio_t", mdio_t, expT);
        if (!expT) check("mdio_o", mdio_o, expO);
      end
      if (wr_valid) begin
        wrCnt++;
        check("wr_valid width", wrPrev, 0);
        check("wr expected", qA.size() != 0, 1);
        if (qA.size() != 0) begin
          check("wr_reg_addr", wr_reg_addr, qA.pop_front());
          check("wr_data", wr_data, qD.pop_front());
        end
      end
      wrPrev = wr_valid;
    end
  end

  // One MDC period: master changes data at the fall, samples the pad just before the rise.
  task automatic mbit(input logic b, input logic eT, input logic eO, output logic rd);
    chkEn = 1'b0;
    expT  = eT;
    expO  = eO;
    mdc_i = 1'b0;
    mdio_i = b;
    tick(5);
    chkEn = 1'b1;
    tick(1);
    rd = mdio_t ? 1'b1 : mdio_o;
    mdc_i = 1'b1;
    tick(6);
    trail = b ? trail + 1 : 0;
  endtask

  task automatic idle(input int n);
    logic rd;
    for (int i = 0; i < n; i++) mbit(1'b1, 1'b1, 1'b1, rd);
    onesRun += n;
  endtask

  task automatic doAbort(input logic drv);
    chkEn = 1'b0;
    mdc_i = 1'b0;
    mdio_i = 1'b1;
    tick(5);
    check("mdio_t before reset", mdio_t, !drv);
    reset = 1'b1;
    @(posedge clk125);
    #1;
    check("mdio_t after reset", mdio_t, 1);
    check("mdio_o after reset", mdio_o, 1);
    check("busy after reset", busy, 0);
    tick(2);
    reset = 1'b0;
    mdc_i = 1'b1;
    mdlReset();
    onesRun = 0;
    trail = 0;
    tick(6);
  endtask

  // Whole frame: decide the responder's behaviour from the frame fields, then clock it out.
  task automatic frame(input int pre, input logic isRd, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd, input int abortAt,
                       output logic [15:0] rdv);
    logic [31:0] fr;
    logic [15:0] ev;
    logic preOk, resp, drv, eo, rd;
    int tot;
    tot = onesRun + pre;
`ifdef MDIO_SLAVE_PREAMBLE_EN
    preOk = (tot >= 32);
`else
    preOk = (tot >= 1);
`endif
    resp = preOk && (phy == 5'd1);
    ev   = mdl[ra];
    rdv  = 16'hFFFF;
    fr   = {2'b01, (isRd ? 2'b10 : 2'b01), phy, ra,
            (isRd ? 2'b11 : 2'b10), (isRd ? 16'hFFFF : wd)};
    if (!isRd && resp && ra != 5'd2 && ra != 5'd3) begin
      mdl[ra] = wd;
      qA.push_back(ra);
      qD.push_back(wd);
    end
    for (int i = 0; i < pre; i++) mbit(1'b1, 1'b1, 1'b1, rd);
    for (int k = 0; k < 32; k++) begin
      drv = isRd && resp && (k >= 15);
      if (k == abortAt) begin
        doAbort(drv);
        return;
      end
      eo = 1'b0;
      if (k >= 16) eo = ev[31-k];
      mbit(fr[31-k], !drv, eo, rd);
      if (k >= 16) rdv[31-k] = rd;
      if (k == 3) check("busy mid", busy, preOk);
    end
    check("wr queue drained", qA.size(), 0);
    onesRun = preOk ? 0 : trail;
    idle(2);
    check("busy idle", busy, 0);
  endtask

  initial begin
    logic [15:0] rdv, exp;
    int w0, pre;
    logic isRd;
    logic [4:0] phy, ra;
    logic [15:0] wd;
    mdlReset();
    reset = 1'b1;
    tick(4);
    check("reset mdio_o", mdio_o, 1);
    check("reset mdio_t", mdio_t, 1);
    check("reset wr_valid", wr_valid, 0);
    check("reset wr_reg_addr", wr_reg_addr, 0);
    check("reset wr_data", wr_data, 0);
    check("reset busy", busy, 0);
    reset = 1'b0;
    tick(2);
    idle(2);

    // Write reg 4 then read it back.
    w0 = wrCnt;
    frame(32, 1'b0, 5'd1, 5'd4, 16'h01E1, -1, rdv);
    check("write pulse count", wrCnt - w0, 1);
    check("write addr literal", wr_reg_addr, 5'd4);
    check("write data literal", wr_data, 16'h01E1);
    frame(32, 1'b1, 5'd1, 5'd4, 16'h0, -1, rdv);
    check("read reg4 literal", rdv, 16'h01E1);

    // ID register and foreign PHY.
    frame(32, 1'b1, 5'd1, 5'd2, 16'h0, -1, rdv);
    check("read reg2 literal", rdv, 16'h0022);
    frame(32, 1'b1, 5'd5, 5'd0, 16'h0, -1, rdv);
    check("foreign phy undriven", rdv, 16'hFFFF);

    // Read-only write is dropped.
    w0 = wrCnt;
    frame(32, 1'b0, 5'd1, 5'd3, 16'hFFFF, -1, rdv);
    check("ro write no pulse", wrCnt - w0, 0);
    frame(32, 1'b1, 5'd1, 5'd3, 16'h0, -1, rdv);
    check("read reg3 literal", rdv, 16'h1620);

    // Short preamble of exactly 31 ones.
    frame(31 - onesRun, 1'b1, 5'd1, 5'd2, 16'h0, -1, rdv);
`ifdef MDIO_SLAVE_PREAMBLE_EN
    check("pre31 read", rdv, 16'hFFFF);
`else
    check("pre31 read", rdv, 16'h0022);
`endif
    idle(34);

    // Reset in the middle of RDATA bit 8, then recovery.
    frame(32, 1'b1, 5'd1, 5'd2, 16'h0, 23, rdv);
    idle(34);
    frame(32, 1'b1, 5'd1, 5'd2, 16'h0, -1, rdv);
    check("read after reset", rdv, 16'h0022);
    frame(32, 1'b1, 5'd1, 5'd4, 16'h0, -1, rdv);
    check("reg4 reloaded", rdv, 16'h0000);

    // Random traffic.
    for (int n = 0; n < 30; n++) begin
      isRd = 1'($urandom_range(0, 1));
      phy  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(2, 31)) : 5'd1;
      ra   = 5'($urandom_range(0, 31));
      wd   = 16'($urandom);
`ifdef MDIO_SLAVE_PREAMBLE_EN
      pre = 32 + $urandom_range(0, 2);
`else
      pre = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 3) : 32;
`endif
      exp = (phy == 5'd1) ? mdl[ra] : 16'hFFFF;
      w0  = wrCnt;
      frame(pre, isRd, phy, ra, wd, -1, rdv);
      if (isRd) check("random read", rdv, exp);
      else check("random write pulses", wrCnt - w0,
                 (phy == 5'd1 && ra != 5'd2 && ra != 5'd3) ? 1 : 0);
    end

    chkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
